// File: rtl/simon_block_feeder.sv
// Byte-stream to block feeder for the SIMON 48/72 core: packs bytes MSB-first, queues blocks, drives newData/BLOCK.
// Define SIMON_FEEDER_CBC_EN to XOR each presented block with the previous ciphertext (IV after reset).
module simon_block_feeder #(
  parameter int N     = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     R,
  input  logic [7:0]               byteIn,
  input  logic                     byteValid,
  output logic                     byteReady,
  output logic [1:0][N-1:0]        BLOCK,
  output logic                     newData,
  input  logic                     loadData,
  input  logic                     doneData,
  input  logic [1:0][N-1:0]        outData,
  input  logic [1:0][N-1:0]        IV,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int W   = 2 * N;
  localparam int BPB = W / 8;
  localparam int CW  = (BPB > 1) ? $clog2(BPB) : 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = $clog2(W);
  localparam logic [CW-1:0] LAST_BYTE = CW'(BPB - 1);
  localparam logic [AW:0]   FULL_LVL  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESENT   = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

  logic [CW-1:0] cnt_r;
  logic [W-1:0]  asm_r;
  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   level_r;
  state_t        state_r;
  logic [W-1:0]  block_r;
  logic          new_data_r;

  logic          byte_ready_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic [PW-1:0] pos_s;
  logic [W-1:0]  push_word_s;
  logic [W-1:0]  chain_s;
  logic [W-1:0]  head_s;

`ifdef SIMON_FEEDER_CBC_EN
  logic [W-1:0] chain_r;

  // Chain value: IV while in reset, then the last ciphertext the core reported.
  always_ff @(posedge clk) begin
    if (R) begin
      chain_r <= IV;
    end else if ((state_r == WAIT_DONE) && doneData) begin
      chain_r <= outData;
    end
  end

  assign chain_s = chain_r;
`else
  logic unused_s;
  assign unused_s = ^{IV, outData};
  assign chain_s  = {W{1'b0}};
`endif

  // Handshake decode; the last byte of a block may only enter when a FIFO slot is free.
  always_comb begin
    byte_ready_s = !((level_r == FULL_LVL) && (cnt_r == LAST_BYTE));
    accept_s     = byteValid && byte_ready_s;
    push_s       = accept_s && (cnt_r == LAST_BYTE);
    pop_s        = (state_r == PRESENT) && loadData;
    pos_s        = PW'(W - 8) - PW'({cnt_r, 3'b000});
    push_word_s  = {asm_r[W-1:8], byteIn};
    head_s       = mem_r[rd_ptr_r] ^ chain_s;
  end

  // Byte assembly: byte 0 lands in the top byte lane, later bytes move down.
  always_ff @(posedge clk) begin
    if (R) begin
      cnt_r <= {CW{1'b0}};
      asm_r <= {W{1'b0}};
    end else if (accept_s) begin
      asm_r[pos_s +: 8] <= byteIn;
      cnt_r             <= (cnt_r == LAST_BYTE) ? {CW{1'b0}} : cnt_r + 1'b1;
    end
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= push_word_s;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (R) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + 1'b1;
        2'b01:   level_r <= level_r - 1'b1;
        default: level_r <= level_r;
      endcase
    end
  end

  // Issue FSM with registered newData/BLOCK; BLOCK only changes on entry to PRESENT.
  always_ff @(posedge clk) begin
    if (R) begin
      state_r    <= IDLE;
      new_data_r <= 1'b0;
      block_r    <= {W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (level_r != {(AW + 1){1'b0}}) begin
            state_r    <= PRESENT;
            new_data_r <= 1'b1;
            block_r    <= head_s;
          end
        end
        PRESENT: begin
          if (loadData) begin
            state_r    <= WAIT_DONE;
            new_data_r <= 1'b0;
          end
        end
        WAIT_DONE: begin
          if (doneData) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r    <= IDLE;
          new_data_r <= 1'b0;
        end
      endcase
    end
  end

  assign byteReady = byte_ready_s;
  assign newData   = new_data_r;
  assign BLOCK     = block_r;
  assign level     = level_r;

endmodule

// File: tb/tb_simon_block_feeder.sv
// Self-checking bench for simon_block_feeder: directed table/sequences plus random traffic against a queue-based model.
module tb_simon_block_feeder;
  localparam int N = 24;
  localparam int DEPTH = 4;
  localparam int W = 2 * N;
  localparam int BPB = W / 8;

  logic clk = 1'b0;
  logic R = 1'b1;
  logic [7:0] byteIn = 8'h00;
  logic byteValid = 1'b0;
  logic byteReady;
  logic [1:0][N-1:0] BLOCK;
  logic newData;
  logic loadData = 1'b0;
  logic doneData = 1'b0;
  logic [1:0][N-1:0] outData = '0;
  logic [1:0][N-1:0] IV = '0;
  logic [$clog2(DEPTH):0] level;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  simon_block_feeder #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .R(R), .byteIn(byteIn), .byteValid(byteValid), .byteReady(byteReady),
    .BLOCK(BLOCK), .newData(newData), .loadData(loadData), .doneData(doneData),
    .outData(outData), .IV(IV), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: bytes collect into a partial list, full blocks go to a queue.
  byte unsigned  m_part[$];
  logic [W-1:0]  m_q[$];
  int            m_phase = 0;  // 0 idle, 1 presenting, 2 waiting for done
  logic [W-1:0]  m_block = '0;
  logic [W-1:0]  m_chain = '0;

  function automatic logic [W-1:0] pack(input byte unsigned p[$]);
    logic [W-1:0] v = '0;
    foreach (p[i]) v = (v << 8) | W'(p[i]);
    return v;
  endfunction

  function automatic bit m_ready();
    return !(m_q.size() == DEPTH && m_part.size() == BPB - 1);
  endfunction

  task automatic model_step();
    bit rdy;
    cyc++;
    if (R) begin
      m_q.delete();
      m_part.delete();
      m_phase = 0;
      m_block = '0;
`ifdef SIMON_FEEDER_CBC_EN
      m_chain = IV;
`endif
    end else begin
      rdy = m_ready();
      case (m_phase)
        0: if (m_q.size() > 0) begin m_phase = 1; m_block = m_q[0] ^ m_chain; end
        1: if (loadData) begin void'(m_q.pop_front()); m_phase = 2; end
        2: if (doneData) begin
             m_phase = 0;
`ifdef SIMON_FEEDER_CBC_EN
             m_chain = outData;
`endif
           end
        default: m_phase = 0;
      endcase
      if (byteValid && rdy) begin
        m_part.push_back(byteIn);
        if (m_part.size() == BPB) begin
          m_q.push_back(pack(m_part));
          m_part.delete();
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      check("mdl_newData", W'(newData), W'(m_phase == 1));
      check("mdl_BLOCK", BLOCK, m_block);
      check("mdl_level", W'(level), W'(m_q.size()));
      check("mdl_byteReady", W'(byteReady), W'(m_ready()));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byteIn = b;
    byteValid = 1'b1;
    while (!byteReady && n < 300) begin tick(); n++; end
    check("send_wait", W'(byteReady), W'(1'b1));
    tick();
    byteValid = 1'b0;
  endtask

  task automatic send_block(input logic [W-1:0] w);
    for (int i = 0; i < BPB; i++) send_byte(8'(w >> (8 * (BPB - 1 - i))));
  endtask

  task automatic wait_nd();
    int n = 0;
    while (!newData && n < 300) begin tick(); n++; end
    check("newData_wait", W'(newData), W'(1'b1));
  endtask

  task automatic pulse_load();
    loadData = 1'b1; tick(); loadData = 1'b0;
  endtask

  task automatic pulse_done();
    doneData = 1'b1; tick(); doneData = 1'b0;
  endtask

  task automatic do_reset();
    R = 1'b1; byteValid = 1'b0; loadData = 1'b0; doneData = 1'b0;
    tick(); tick();
    R = 1'b0;
  endtask

  typedef struct {
    logic [W-1:0] word;
    logic [W-1:0] exp;
  } vec_t;
  vec_t tbl[5];

  initial begin
    tbl[0] = '{48'h6120676E696C, 48'h6120676E696C};
    tbl[1] = '{48'hA8D5F7DE0123, 48'hA8D5F7DE0123};
    tbl[2] = '{48'h5BC92D014567, 48'h5BC92D014567};
    tbl[3] = '{48'hF2B48D4589AB, 48'hF2B48D4589AB};
    tbl[4] = '{48'h567F11DECDEF, 48'h567F11DECDEF};

    tick(); tick();
    R = 1'b0;
    check_en = 1'b1;
    check("rst_newData", W'(newData), W'(1'b0));
    check("rst_BLOCK", BLOCK, 48'h0);
    check("rst_byteReady", W'(byteReady), W'(1'b1));
    check("rst_level", W'(level), W'(0));

    // Single block, back-to-back bytes.
    send_block(48'h6120676E696C);
    check("t1_level", W'(level), W'(1));
    check("t1_nd_early", W'(newData), W'(1'b0));
    tick();
    check("t1_newData", W'(newData), W'(1'b1));
    check("t1_BLOCK", BLOCK, 48'h6120676E696C);
    pulse_load();
    check("t1_nd_drop", W'(newData), W'(1'b0));
    check("t1_level0", W'(level), W'(0));
    pulse_done();

    // Spurious handshakes.
    pulse_load();
    check("sp_idle_nd", W'(newData), W'(1'b0));
    check("sp_idle_lvl", W'(level), W'(0));
    send_block(48'hA8D5F7DE0123);
    pulse_load();
    check("sp_idle2_nd", W'(newData), W'(1'b1));
    check("sp_idle2_lvl", W'(level), W'(1));
    pulse_done();
    check("sp_pres_nd", W'(newData), W'(1'b1));
    check("sp_pres_lvl", W'(level), W'(1));
    check("sp_pres_blk", BLOCK, 48'hA8D5F7DE0123);
    pulse_load();
    check("sp_pop_lvl", W'(level), W'(0));
    pulse_load();
    pulse_done();

    // Five blocks with a 40-cycle core.
    IV = '0; outData = '0;
    do_reset();
    fork
      begin
        for (int b = 0; b < 5; b++) send_block(tbl[b].word);
      end
      begin
        int last_done = -100;
        for (int b = 0; b < 5; b++) begin
          wait_nd();
          check("t2_gap", W'((cyc - last_done) >= 2), W'(1'b1));
          check("t2_block", BLOCK, tbl[b].exp);
          pulse_load();
          repeat (39) tick();
          doneData = 1'b1; last_done = cyc; tick(); doneData = 1'b0;
        end
      end
    join

    // Full FIFO back-pressure on the final byte of block 5.
    do_reset();
    for (int b = 0; b < 4; b++) send_block(tbl[b].word);
    for (int i = 1; i <= 5; i++) send_byte(8'(8'h10 + i));
    check("t3_level_full", W'(level), W'(4));
    check("t3_ready_low", W'(byteReady), W'(1'b0));
    byteIn = 8'h16; byteValid = 1'b1; loadData = 1'b1;
    tick();
    loadData = 1'b0;
    check("t3_ready_back", W'(byteReady), W'(1'b1));
    check("t3_level3", W'(level), W'(3));
    tick();
    byteValid = 1'b0;
    check("t3_level4", W'(level), W'(4));
    for (int b = 1; b < 5; b++) begin
      pulse_done();
      wait_nd();
      check("t3_drain", BLOCK, (b < 4) ? tbl[b].exp : 48'h111213141516);
      pulse_load();
    end
    pulse_done();

    // Reset in the middle of presenting.
    do_reset();
    send_block(tbl[0].word);
    send_block(tbl[1].word);
    for (int i = 0; i < 3; i++) send_byte(8'hEE);
    wait_nd();
    R = 1'b1; loadData = 1'b1;
    tick();
    R = 1'b0; loadData = 1'b0;
    check("t4_nd", W'(newData), W'(1'b0));
    check("t4_level", W'(level), W'(0));
    send_block(48'hA1A2A3A4A5A6);
    wait_nd();
    check("t4_fresh", BLOCK, 48'hA1A2A3A4A5A6);
    pulse_load();
    pulse_done();

`ifdef SIMON_FEEDER_CBC_EN
    IV = 48'h000000FFFFFF;
    do_reset();
    send_block(48'h6120676E696C);
    wait_nd();
    check("cbc_iv", BLOCK, 48'h612067919693);
    pulse_load();
    outData = 48'h111111111111;
    pulse_done();
    outData = '0;
    send_block(48'h0);
    wait_nd();
    check("cbc_chain", BLOCK, 48'h111111111111);
    pulse_load();
    pulse_done();
`endif

    // Random traffic checked by the model every cycle.
    IV = W'({$urandom(), $urandom()});
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      byteValid = ($urandom_range(9) < 7);
      byteIn    = 8'($urandom());
      loadData  = newData ? ($urandom_range(2) == 0) : ($urandom_range(19) == 0);
      doneData  = ($urandom_range(7) == 0);
      outData   = W'({$urandom(), $urandom()});
      R         = ($urandom_range(799) == 0);
      tick();
    end
    R = 1'b0; byteValid = 1'b0; loadData = 1'b0; doneData = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
